fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//   Instruction queue between the PC/instruction-memory fetch stage and decode.
//   Captures each fetched {pc, instr} pair and presents it to decode with a
//   valid/ready handshake. Decouples fetch from decode stalls and discards
//   wrong-path instructions on a branch/jump flush.
//   Back-pressures the fetch stage through fetch_stall when full.
// PARAMETERS
//   DEPTH   4    queue entries; power of two, >= 2
//   AW      2    pointer width, log2(DEPTH)
//   RST_PC  32'h3000  id_pc value driven while empty (matches PC reset vector)
// PORTS
//   clk          in   1   clock, all state on posedge
//   rstn         in   1   asynchronous active-low reset
//   if_valid     in   1   fetch slot valid (IM read enable of the PC stage)
//   if_pc        in   32  address of fetched instruction
//   if_instr     in   32  fetched instruction word
//   fetch_stall  out  1   queue full; fetch must hold pc and retry
//   flush        in   1   redirect: discard all queued and same-cycle entries
//   id_valid     out  1   head entry valid for decode
//   id_ready     in   1   decode accepts head entry this cycle
//   id_pc        out  32  pc of head entry
//   id_instr     out  32  instruction of head entry
//   count        out  AW+1  occupancy, 0..DEPTH
// BEHAVIOUR
//   Reset (rstn=0, async): wr_ptr=rd_ptr=0, count=0, all entries cleared.
//     Outputs: fetch_stall=0, id_valid=0, id_pc=RST_PC, id_instr=32'h0.
//   push = if_valid & ~full & ~flush; pop = id_valid & id_ready & ~flush.
//   full = (count==DEPTH); empty = (count==0); fetch_stall = full, combinational from count.
//   Push writes entry[wr_ptr] <= {if_pc, if_instr}, wr_ptr+1 (wraps mod DEPTH).
//   Pop advances rd_ptr+1 (wraps mod DEPTH).
//   count: +1 on push only, -1 on pop only, unchanged on push&pop.
//   No bypass: an entry pushed in cycle N is first visible on id_* in cycle N+1.
//   Full with pop in same cycle: push still rejected (fetch_stall was 1).
//     Fetch retries the next cycle.
//   Empty: id_valid=0, id_pc=RST_PC, id_instr=32'h0 (NOP, sll $0,$0,0).
//     id_ready is ignored.
//   Non-empty: id_valid=1, id_pc/id_instr = entry[rd_ptr], held stable until popped.
//   flush (sync, highest priority): next cycle count=0, wr_ptr=rd_ptr=0, id_valid=0.
//     Same-cycle push and pop are discarded.
//   if_valid=0: no push regardless of if_pc/if_instr (covers PC-stage reset cycle).
//   Reset asserted mid-operation: immediate return to reset state, queued entries lost.
//   count never exceeds DEPTH and never underflows. Assertions check both.
// TESTING
//   Reset: rstn=0 with if_valid=1 -> id_valid=0, id_pc=32'h3000, id_instr=0, count=0.
//     Release -> first push visible 1 cycle later.
//   Stream: if_valid=1 each cycle with pc 3000,3004,3008..., id_ready=1.
//     -> id_pc sequence 3000,3004,... one cycle behind, count stays 1.
//   Fill: id_ready=0, push 5 words (DEPTH=4) -> fetch_stall=1 after 4th push, count=4.
//     5th word not stored until id_ready=1 frees a slot.
//   Full+pop: count=4, id_ready=1, if_valid=1 -> pop only, count=3.
//     Next cycle push accepted, wrapped entry order preserved.
//   Flush: count=3, flush=1 with if_valid=1 and id_ready=1 -> next cycle count=0, id_valid=0.
//     Following push of pc 3040 appears as the only head.
//   Wrap: 10 push/pop cycles at DEPTH=4 -> pointers wrap twice, id_pc order exactly matches pushes.

Source files
------------

// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: buffers {pc, instr} pairs from the fetch
// stage, back-pressures fetch when full and drops wrong-path entries on flush.
module fetch_queue #(
  parameter int          DEPTH  = 4,
  parameter int          AW     = 2,
  parameter logic [31:0] RST_PC = 32'h3000
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          if_valid,
  input  logic [31:0]   if_pc,
  input  logic [31:0]   if_instr,
  output logic          fetch_stall,
  input  logic          flush,
  output logic          id_valid,
  input  logic          id_ready,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_instr,
  output logic [AW:0]   count
);

  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [31:0]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Handshakes: a transfer happens on a cycle where valid and ready are both
  // high at the clock edge. Fetch side: valid=if_valid, ready=~fetch_stall.
  // Decode side: valid=id_valid, ready=id_ready. flush cancels both transfers.
  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign fetch_stall = full;
  assign push        = if_valid & ~full & ~flush;
  assign pop         = id_valid & id_ready & ~flush;

  // No bypass: the head is always read from storage, an empty queue shows a NOP.
  assign id_valid = ~empty;
  assign id_pc    = empty ? RST_PC : mem_pc[rd_ptr];
  assign id_instr = empty ? 32'h0  : mem_instr[rd_ptr];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_pc[i]    <= '0;
        mem_instr[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem_pc[wr_ptr]    <= if_pc;
        mem_instr[wr_ptr] <= if_instr;
        wr_ptr            <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

  // A wrapped (underflowed) count would also exceed DEPTH.
  a_count_max: assert property (@(posedge clk) disable iff (!rstn) count <= CNT_FULL);
  a_no_underflow: assert property (@(posedge clk) disable iff (!rstn)
                                   (empty |=> count <= CNT_ONE));

endmodule
